// File: rtl/noc_pkg.sv
// Shared constants for the NoC router: port indices, route modes and the
// helpers that locate the destination coordinate fields inside a flit.
package noc_pkg;

  localparam int P_X     = 0;
  localparam int P_Y     = 1;
  localparam int P_LOCAL = 2;
  localparam int NPORT   = 3;

  localparam int RM_XY = 0;
  localparam int RM_YX = 1;

  // Coordinates occupy the top of the flit: dest_x first, dest_y below it.
  function automatic int dest_x_msb(int dw);
    return dw - 1;
  endfunction

  function automatic int dest_y_msb(int dw, int cw);
    return dw - 1 - cw;
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Single-clock flit FIFO with a combinational head so routing can inspect
// the oldest entry in the same cycle it is popped.
module noc_sync_fifo #(
  parameter int DW    = 40,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [DW-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/noc_router_core.sv
// Three-port dimension-ordered router: per-input FIFOs, per-output round-robin
// arbiters and a registered output stage with independent valid/ready per port.
module noc_router_core
  import noc_pkg::*;
#(
  parameter int DW         = 40,
  parameter int DEPTH      = 8,
  parameter int COORD_W    = 2,
  parameter int ROUTE_MODE = 0,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [COORD_W-1:0]   cur_x,
  input  logic [COORD_W-1:0]   cur_y,
  input  logic [2:0]           in_valid,
  input  logic [3*DW-1:0]      in_data,
  output logic [2:0]           in_ready,
  output logic [2:0]           out_valid,
  output logic [3*DW-1:0]      out_data,
  input  logic [2:0]           out_ready,
  input  logic                 cnt_clr,
  output logic [3*CNT_W-1:0]   conflict_cnt
);

  localparam int XM = dest_x_msb(DW);
  localparam int YM = dest_y_msb(DW, COORD_W);

  logic [NPORT-1:0] fifo_full, fifo_empty, push, pop, can_load;
  logic [DW-1:0]    head [NPORT];
  logic [1:0]       route [NPORT];
  logic [NPORT-1:0] req [NPORT];
  logic [NPORT-1:0] gnt_any;
  logic [1:0]       gnt_idx [NPORT];

  logic [NPORT-1:0] out_valid_q, out_valid_d;
  logic [DW-1:0]    out_data_q [NPORT];
  logic [DW-1:0]    out_data_d [NPORT];
  logic [1:0]       ptr_q [NPORT];
  logic [1:0]       ptr_d [NPORT];
  logic [CNT_W-1:0] cnt_q [NPORT];
  logic [CNT_W-1:0] cnt_d [NPORT];

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_in
    logic x_diff, y_diff;

    noc_sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push[gi]),
      .data_i  (in_data[gi*DW +: DW]),
      .pop_i   (pop[gi]),
      .full_o  (fifo_full[gi]),
      .empty_o (fifo_empty[gi]),
      .head_o  (head[gi])
    );

    assign in_ready[gi] = !fifo_full[gi];
    assign push[gi]     = in_valid[gi] && !fifo_full[gi];
    assign x_diff       = (head[gi][XM -: COORD_W] != cur_x);
    assign y_diff       = (head[gi][YM -: COORD_W] != cur_y);

    if (ROUTE_MODE == RM_YX) begin : g_yx
      assign route[gi] = y_diff ? 2'(P_Y) : (x_diff ? 2'(P_X) : 2'(P_LOCAL));
    end else begin : g_xy
      assign route[gi] = x_diff ? 2'(P_X) : (y_diff ? 2'(P_Y) : 2'(P_LOCAL));
    end
  end

  for (genvar gi = 0; gi < NPORT; gi++) begin : g_out
    assign can_load[gi]                    = !out_valid_q[gi] || out_ready[gi];
    assign out_data[gi*DW +: DW]           = out_data_q[gi];
    assign conflict_cnt[gi*CNT_W +: CNT_W] = cnt_q[gi];
  end

  assign out_valid = out_valid_q;

  // Search starts one past the last winner, so the previous winner ranks last.
  always_comb begin
    logic [1:0] idx;
    idx = '0;
    pop = '0;
    for (int o = 0; o < NPORT; o++) begin
      gnt_any[o] = 1'b0;
      gnt_idx[o] = ptr_q[o];
      for (int p = 0; p < NPORT; p++) begin
        req[o][p] = can_load[o] && !fifo_empty[p] && (route[p] == 2'(o));
      end
      for (int k = 1; k <= NPORT; k++) begin
        idx = 2'((int'(ptr_q[o]) + k) % NPORT);
        if (!gnt_any[o] && req[o][idx]) begin
          gnt_any[o] = 1'b1;
          gnt_idx[o] = idx;
        end
      end
      if (gnt_any[o]) pop[gnt_idx[o]] = 1'b1;
    end
  end

  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      out_valid_d[o] = out_valid_q[o];
      out_data_d[o]  = out_data_q[o];
      ptr_d[o]       = ptr_q[o];
      cnt_d[o]       = cnt_q[o];
      if (gnt_any[o]) begin
        out_valid_d[o] = 1'b1;
        out_data_d[o]  = head[gnt_idx[o]];
        ptr_d[o]       = gnt_idx[o];
      end else if (out_ready[o]) begin
        out_valid_d[o] = 1'b0;
      end
      if (cnt_clr) begin
        cnt_d[o] = '0;
      end else if (($countones(req[o]) >= 2) && (cnt_q[o] != {CNT_W{1'b1}})) begin
        cnt_d[o] = cnt_q[o] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= '0;
      for (int o = 0; o < NPORT; o++) begin
        out_data_q[o] <= '0;
        ptr_q[o]      <= 2'd2;
        cnt_q[o]      <= '0;
      end
    end else begin
      out_valid_q <= out_valid_d;
      for (int o = 0; o < NPORT; o++) begin
        out_data_q[o] <= out_data_d[o];
        ptr_q[o]      <= ptr_d[o];
        cnt_q[o]      <= cnt_d[o];
      end
    end
  end

endmodule

// File: tb/tb_noc_router_core.sv
// Self-checking bench: an XY and a YX router share stimulus and are compared
// every cycle against a queue-based model of the routing/arbitration rules.
module tb_noc_router_core;

  localparam int DW    = 40;
  localparam int DEPTH = 8;
  localparam int CW    = 2;
  localparam int CNT_W = 4;
  localparam int NP    = 3;
  localparam int PW    = DW - 2*CW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [CW-1:0]      cur_x, cur_y;
  logic [2:0]         in_valid, out_ready;
  logic [3*DW-1:0]    in_data;
  logic               cnt_clr;

  logic [2:0]         in_ready_xy, out_valid_xy, in_ready_yx, out_valid_yx;
  logic [3*DW-1:0]    out_data_xy, out_data_yx;
  logic [3*CNT_W-1:0] conflict_cnt_xy, conflict_cnt_yx;

  noc_router_core #(.DW(DW), .DEPTH(DEPTH), .COORD_W(CW), .ROUTE_MODE(0), .CNT_W(CNT_W)) u_dut_xy (
    .clk(clk), .rst_n(rst_n), .cur_x(cur_x), .cur_y(cur_y),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_xy),
    .out_valid(out_valid_xy), .out_data(out_data_xy), .out_ready(out_ready),
    .cnt_clr(cnt_clr), .conflict_cnt(conflict_cnt_xy)
  );

  noc_router_core #(.DW(DW), .DEPTH(DEPTH), .COORD_W(CW), .ROUTE_MODE(1), .CNT_W(CNT_W)) u_dut_yx (
    .clk(clk), .rst_n(rst_n), .cur_x(cur_x), .cur_y(cur_y),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_yx),
    .out_valid(out_valid_yx), .out_data(out_data_yx), .out_ready(out_ready),
    .cnt_clr(cnt_clr), .conflict_cnt(conflict_cnt_yx)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model, index d: 0 = XY router, 1 = YX router.
  logic [DW-1:0] mq [2*NP][$];
  bit            m_ov  [2][NP];
  logic [DW-1:0] m_od  [2][NP];
  int            m_ptr [2][NP];
  int            m_cnt [2][NP];

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int dx, input int dy, input int pl);
    return {CW'(dx), CW'(dy), PW'(pl)};
  endfunction

  function automatic int route_of(input logic [DW-1:0] f, input int mode);
    logic [CW-1:0] dx = f[DW-1 -: CW];
    logic [CW-1:0] dy = f[DW-1-CW -: CW];
    bit xd = (dx != cur_x);
    bit yd = (dy != cur_y);
    if (mode == 0) return xd ? 0 : (yd ? 1 : 2);
    return yd ? 1 : (xd ? 0 : 2);
  endfunction

  task automatic model_step();
    bit rdy [NP];
    int dest [NP];
    int nreq, win, p;
    bit can;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        for (int i = 0; i < NP; i++) begin
          mq[d*NP+i].delete();
          m_ov[d][i] = 0; m_od[d][i] = '0; m_ptr[d][i] = 2; m_cnt[d][i] = 0;
        end
      end else begin
        for (int i = 0; i < NP; i++) begin
          rdy[i]  = mq[d*NP+i].size() < DEPTH;
          dest[i] = (mq[d*NP+i].size() > 0) ? route_of(mq[d*NP+i][0], d) : -1;
        end
        for (int o = 0; o < NP; o++) begin
          can  = !m_ov[d][o] || out_ready[o];
          nreq = 0;
          for (int i = 0; i < NP; i++) if (dest[i] == o) nreq++;
          if (can && nreq > 0) begin
            win = -1;
            for (int k = 1; k <= NP; k++) begin
              p = (m_ptr[d][o] + k) % NP;
              if (win < 0 && dest[p] == o) win = p;
            end
            m_od[d][o]  = mq[d*NP+win].pop_front();
            m_ov[d][o]  = 1;
            m_ptr[d][o] = win;
          end else if (out_ready[o]) begin
            m_ov[d][o] = 0;
          end
          if (cnt_clr) m_cnt[d][o] = 0;
          else if (can && nreq >= 2 && m_cnt[d][o] < (1 << CNT_W) - 1) m_cnt[d][o]++;
        end
        for (int i = 0; i < NP; i++)
          if (in_valid[i] && rdy[i]) mq[d*NP+i].push_back(in_data[i*DW +: DW]);
      end
    end
  endtask

  task automatic compare_all();
    logic [2:0] e_ov, e_rdy, g_ov, g_rdy;
    logic [3*DW-1:0] e_od, g_od;
    logic [3*CNT_W-1:0] e_cnt, g_cnt;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NP; i++) begin
        e_ov[i] = m_ov[d][i];
        e_rdy[i] = mq[d*NP+i].size() < DEPTH;
        e_od[i*DW +: DW] = m_od[d][i];
        e_cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[d][i]);
      end
      g_ov  = (d == 0) ? out_valid_xy    : out_valid_yx;
      g_rdy = (d == 0) ? in_ready_xy     : in_ready_yx;
      g_od  = (d == 0) ? out_data_xy     : out_data_yx;
      g_cnt = (d == 0) ? conflict_cnt_xy : conflict_cnt_yx;
      check_val($sformatf("d%0d out_valid", d), 128'(g_ov), 128'(e_ov));
      check_val($sformatf("d%0d in_ready", d), 128'(g_rdy), 128'(e_rdy));
      check_val($sformatf("d%0d out_data", d), 128'(g_od), 128'(e_od));
      check_val($sformatf("d%0d conflict_cnt", d), 128'(g_cnt), 128'(e_cnt));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    compare_all();
  endtask

  task automatic idle();
    in_valid = '0;
    cnt_clr  = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    out_ready = '1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] f, fx, fl, o;
    int n, total, src;
    int tally [NP];

    cur_x = 2'd1; cur_y = 2'd1;
    in_data = '0; idle(); out_ready = '1;

    // Reset state
    do_reset();
    check_val("reset in_ready", 128'(in_ready_xy), 128'(3'b111));
    check_val("reset out_valid", 128'(out_valid_xy), 128'(3'b000));
    check_val("reset conflict", 128'(conflict_cnt_xy), 128'(0));

    // Single uncontended flit: accepted at E0, visible after E1
    f = mk(2, 1, 'h111);
    in_valid = 3'b001; in_data[0 +: DW] = f;
    tick();
    check_val("lat E0 out_valid", 128'(out_valid_xy), 128'(3'b000));
    idle();
    tick();
    check_val("lat E1 out_valid", 128'(out_valid_xy), 128'(3'b001));
    check_val("lat E1 out_data", 128'(out_data_xy[0 +: DW]), 128'(f));

    // Route mode: dest (2,3) exits X under XY, Y under YX
    do_reset();
    f = mk(2, 3, 'h222);
    in_valid = 3'b100; in_data[2*DW +: DW] = f;
    tick(); idle(); tick();
    check_val("xy dest23 valid", 128'(out_valid_xy), 128'(3'b001));
    check_val("yx dest23 valid", 128'(out_valid_yx), 128'(3'b010));
    check_val("yx dest23 data", 128'(out_data_yx[DW +: DW]), 128'(f));

    // Two inputs to LOCAL on the same edge
    do_reset();
    fx = mk(1, 1, 'hA); fl = mk(1, 1, 'hB);
    in_valid = 3'b101; in_data[0 +: DW] = fx; in_data[2*DW +: DW] = fl;
    tick(); idle(); tick();
    check_val("conflict first", 128'(out_data_xy[2*DW +: DW]), 128'(fx));
    tick();
    check_val("conflict second", 128'(out_data_xy[2*DW +: DW]), 128'(fl));
    check_val("conflict cnt", 128'(conflict_cnt_xy[2*CNT_W +: CNT_W]), 128'(1));

    // Backpressure on Y while X keeps flowing
    do_reset();
    out_ready = 3'b101;
    for (int i = 0; i < 10; i++) begin
      in_valid = 3'b011;
      in_data[DW +: DW] = mk(1, 0, i);
      in_data[0 +: DW]  = mk(3, 1, 100 + i);
      tick();
      if (i == 7) check_val("bp ready before full", 128'(in_ready_xy[1]), 128'(1));
      if (i == 8) check_val("bp ready after 9th", 128'(in_ready_xy[1]), 128'(0));
    end
    check_val("bp held data", 128'(out_data_xy[DW +: DW]), 128'(mk(1, 0, 0)));
    check_val("bp X flows", 128'(out_data_xy[0 +: DW]), 128'(mk(3, 1, 108)));
    idle(); out_ready = 3'b111;
    n = 1;
    repeat (20) begin
      tick();
      if (out_valid_xy[1]) begin
        check_val("bp drain order", 128'(out_data_xy[DW +: DW]), 128'(mk(1, 0, n)));
        n++;
      end
    end
    check_val("bp drain count", 128'(n), 128'(9));

    // Fairness: all three inputs target LOCAL continuously
    do_reset();
    total = 0;
    for (int i = 0; i < NP; i++) tally[i] = 0;
    for (int t = 0; t < 32; t++) begin
      in_valid = 3'b111;
      for (int i = 0; i < NP; i++) in_data[i*DW +: DW] = mk(1, 1, i + 4*t);
      tick();
      if (out_valid_xy[2] && total < 30) begin
        o = out_data_xy[2*DW +: DW];
        src = int'(o[1:0]);
        check_val("rr grant order", 128'(src), 128'(total % 3));
        tally[src]++;
        total++;
      end
    end
    for (int i = 0; i < NP; i++) check_val($sformatf("rr share %0d", i), 128'(tally[i]), 128'(10));
    check_val("cnt saturated", 128'(conflict_cnt_xy[2*CNT_W +: CNT_W]), 128'(15));
    cnt_clr = 1'b1;
    tick();
    check_val("cnt_clr over inc", 128'(conflict_cnt_xy[2*CNT_W +: CNT_W]), 128'(0));
    cnt_clr = 1'b0;

    // Mid-burst reset
    tick();
    rst_n = 1'b0;
    tick();
    check_val("midrst out_valid", 128'(out_valid_xy), 128'(3'b000));
    check_val("midrst in_ready", 128'(in_ready_xy), 128'(3'b111));
    check_val("midrst conflict", 128'(conflict_cnt_xy), 128'(0));
    rst_n = 1'b1; idle();
    repeat (3) begin
      tick();
      check_val("midrst no stale", 128'(out_valid_xy), 128'(3'b000));
    end

    // Randomized traffic against the model
    cur_x = 2'd1; cur_y = 2'd2;
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      rst_n    = ($urandom_range(0, 300) != 0);
      cnt_clr  = ($urandom_range(0, 40) == 0);
      in_valid = 3'($urandom);
      for (int i = 0; i < NP; i++) begin
        out_ready[i] = ($urandom_range(0, 3) != 0);
        in_data[i*DW +: DW] = mk($urandom_range(0, 3), $urandom_range(0, 3), int'($urandom));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/noc_router_core.md
Name: noc_router_core

Overview:
- Single-clock, parametrised successor of the 3-port (X, Y, LOCAL) router pipeline.
- Buffers flits per input and routes each head flit dimension-ordered (XY or YX, selectable).
- Arbitrates each output round-robin and drives a registered output stage with per-port valid/ready backpressure. A stall on one output no longer freezes the whole router.
- Sits between the network-interface/link FIFOs of neighbouring nodes; also reports per-output conflict statistics.

Parameters:
- DW, 40, flit width in bits (>= 2*COORD_W+1).
- DEPTH, 8, entries per input FIFO; power of 2, >= 2.
- COORD_W, 2, width of each destination coordinate.
- ROUTE_MODE, 0, 0 = XY (X dimension first), 1 = YX.
- CNT_W, 16, width of each conflict counter.

Ports:
- clk  in  1  router clock.
- rst_n  in  1  reset.
- cur_x  in  COORD_W  this node's X coordinate; quasi-static.
- cur_y  in  COORD_W  this node's Y coordinate; quasi-static.
- in_valid  in  3  per-input flit valid; index 0=X, 1=Y, 2=LOCAL.
- in_data  in  3*DW  flattened input flits; port p occupies [p*DW +: DW].
- in_ready  out  3  per-input ready; equals !fifo_full[p].
- out_valid  out  3  per-output flit valid; same indexing.
- out_data  out  3*DW  flattened output flits.
- out_ready  in  3  per-output downstream ready.
- cnt_clr  in  1  synchronous clear of all conflict counters.
- conflict_cnt  out  3*CNT_W  per-output saturating conflict counters.

Behaviour:
- Clock and reset: clk, single clock domain. rst_n is synchronous, active-low. Sampled only at posedge clk; while low, every register takes its reset value at the edge.
- Reset values:
  - FIFOs empty, so in_ready=3'b111 from the first edge after release.
  - out_valid=0, out_data=0, conflict_cnt=0.
  - RR pointers = 2, so input 0 has first priority.
- Flit fields:
  - dest_x = flit[DW-1 -: COORD_W].
  - dest_y = flit[DW-1-COORD_W -: COORD_W].
  - Remaining bits are payload and pass through unmodified.
- Input accept: a flit is accepted on an edge where in_valid[p] && in_ready[p]. in_valid while !in_ready is ignored; no overwrite.
- Route, computed combinationally on each non-empty FIFO head:
  - XY: dest_x != cur_x -> X; else dest_y != cur_y -> Y; else LOCAL.
  - YX: Y test first, then X, then LOCAL.
  - Any input may target any output, including its own index.
- Output stage: one flit register per output. It can load when !out_valid[o] || out_ready[o].
- Arbitration, per output o:
  - Requesters are inputs whose head routes to o, provided output o can load.
  - Grant the first requester at index (ptr_o+1), (ptr_o+2), (ptr_o+3) mod 3. On a grant, ptr_o <= granted index.
  - Each input requests exactly one output, so an input is granted at most once per cycle.
- Transfer: on grant, the head pops and the output register loads on the same edge, setting out_valid[o]=1.
  - A transfer out (out_valid && out_ready) with no new grant clears out_valid[o].
  - Simultaneous drain and load is a full-throughput handoff.
- Latency:
  - Flit accepted at edge E0 appears on out_data at E1 (out_valid high after E1) when uncontended.
  - Throughput is 1 flit/cycle/output.
  - Each losing input waits at least one extra cycle per higher-priority winner.
- Backpressure:
  - out_ready[o]=0 with out_valid[o]=1 holds out_data[o] stable.
  - Inputs routed to other outputs proceed unaffected.
  - A head-blocked FIFO fills; in_ready drops when DEPTH entries are held.
- FIFO boundaries:
  - Push and pop in the same cycle while full: the pop frees space but in_ready is still low that cycle, so no push occurs.
  - Push and pop while empty: not possible, because the head is invalid.
  - Pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
- Conflict counter:
  - conflict_cnt[o] increments on each cycle where output o can load and has >= 2 requesters.
  - Saturates at all-ones.
  - cnt_clr has priority over increment.
- Mid-operation reset: in-flight and buffered flits are discarded; nothing is emitted in the reset cycle.

Decomposition:
- Package noc_pkg holds:
  - port index constants P_X=0, P_Y=1, P_LOCAL=2, NPORT=3;
  - route mode constants RM_XY=0, RM_YX=1;
  - dest field offset functions of DW/COORD_W.
- Sub-module noc_sync_fifo (DW, DEPTH; push/pop/full/empty/head), instantiated 3 times.
- Routing, arbiters and output stage stay inline.

Test Plan:
- Reset, cur=(1,1), XY. Single flit dest (2,1) on X input at E0 -> out_valid[X]=1 after E1 with identical data; other outputs stay 0.
- Same edge: X input flit dest (1,1) and LOCAL input flit dest (1,1) -> output LOCAL emits input X at E1, input LOCAL at E2; conflict_cnt[LOCAL]=1.
- ROUTE_MODE=1, flit dest (2,3) -> exits Y. Same flit with ROUTE_MODE=0 -> exits X.
- Hold out_ready[Y]=0 and send 10 flits to Y via input Y:
  - 1 flit sits in the output register and 8 fill the FIFO;
  - in_ready[Y]=0 after the 9th accepted flit; flits routed to X still flow;
  - releasing out_ready drains all 9 in order.
- Three inputs continuously target LOCAL -> grant order 0,1,2,0,1,2; each input gets exactly 1/3 of cycles over 30 cycles.
- Assert rst_n=0 for one edge mid-burst -> out_valid=0, in_ready=3'b111, conflict_cnt=0 next cycle; no stale flit emerges. cnt_clr at saturation -> 0.
